// File: rtl/fft_frame_sched_pkg.sv
// Shared definitions for the spectrum-display frame path: scheduler state
// encoding and the frame geometry defaults also used by the FIFO and FFT
// wrappers.
package fft_frame_sched_pkg;

  // Scheduler states: reset the FFT, wait for a frame, stream it, wait for eop
  typedef enum logic [1:0] {
    ST_RST_FFT = 2'd0,
    ST_ARM     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_DRAIN   = 2'd3
  } sched_state_t;

  // Samples per FFT frame and the width of FIFO fill counts / sample counters
  localparam int FRAME_LEN_DEF = 1024;
  localparam int CNT_W_DEF     = 11;

  // Width of a down-counter that must hold values 0..n
  function automatic int timer_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fft_frame_sched_down_timer.sv
// Generic load/tick down-counter. expire is high while the count sits at
// zero; the count holds at zero until it is reloaded.
module fft_frame_sched_down_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Reload takes priority; otherwise count down on tick and saturate at zero
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler between the audio FIFO read side and the FFT core.
// Resets the FFT, waits for a full buffered frame and a ready display,
// streams exactly one frame into the FFT, then waits for the FFT's
// end-of-packet. A stalled FFT is recovered by a drain timeout that
// re-resets it.
module fft_frame_sched
  import fft_frame_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RST_CYC   = 4,
  parameter int DRAIN_TO  = 4096
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             enable,
  input  logic             disp_ready,
  input  logic [CNT_W-1:0] fifo_wnum,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             fft_rst,
  output logic             fft_start,
  input  logic             fft_valid,
  input  logic             fft_eop,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             err_underflow,
  output logic             err_timeout
);

  localparam int RST_W = timer_w(RST_CYC);
  localparam int TO_W  = timer_w(DRAIN_TO);

  localparam logic [CNT_W-1:0] FRAME_LEN_C  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] FRAME_LAST_C = CNT_W'(FRAME_LEN - 1);
  // Timers expire at zero, so loading N-1 gives exactly N cycles in state
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(DRAIN_TO - 1);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_go;
  logic             eop_hit;
  logic             underflow_hit;
  logic             timeout_hit;
  logic             rst_expire;
  logic             to_expire;

  // FFT reset pulse length: reloaded whenever we are not in RST_FFT (and on
  // rst), so every entry into RST_FFT starts a fresh RST_CYC count
  fft_frame_sched_down_timer #(
    .W (RST_W)
  ) u_rst_timer (
    .clk      (clk_50m),
    .load     (rst || (state != ST_RST_FFT)),
    .load_val (RST_LOAD),
    .tick     (state == ST_RST_FFT),
    .expire   (rst_expire)
  );

  // Drain timeout: reloaded outside DRAIN, counts DRAIN_TO cycles inside it
  fft_frame_sched_down_timer #(
    .W (TO_W)
  ) u_to_timer (
    .clk      (clk_50m),
    .load     (rst || (state != ST_DRAIN)),
    .load_val (TO_LOAD),
    .tick     (state == ST_DRAIN),
    .expire   (to_expire)
  );

  // Next-state and output decode; rd_en is gated by rst so no sample is
  // popped from the FIFO in a cycle whose frame is about to be abandoned
  always_comb begin
    state_nxt     = state;
    fifo_rd_en    = 1'b0;
    fft_rst       = 1'b0;
    busy          = 1'b1;
    rd_go         = 1'b0;
    eop_hit       = 1'b0;
    underflow_hit = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      ST_RST_FFT: begin
        fft_rst = 1'b1;
        if (rst_expire) begin
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        busy = 1'b0;
        // fifo_wnum may be stale; it only gates the start, never the reads
        if (enable && disp_ready && (fifo_wnum >= FRAME_LEN_C)) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (rd_cnt < FRAME_LEN_C) begin
          if (fifo_empty) begin
            underflow_hit = 1'b1;
          end else begin
            rd_go = 1'b1;
          end
        end
        fifo_rd_en = rd_go && !rst;
        // Leave on the last issued read; its fft_start lands in DRAIN
        if ((rd_go && (rd_cnt == FRAME_LAST_C)) || (rd_cnt >= FRAME_LEN_C)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // eop has priority over a simultaneous timeout
        if (fft_valid && fft_eop) begin
          eop_hit   = 1'b1;
          state_nxt = ST_ARM;
        end else if (to_expire) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RST_FFT;
        end
      end
      default: begin
        state_nxt = ST_RST_FFT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state <= ST_RST_FFT;
    end else begin
      state <= state_nxt;
    end
  end

  // Read counter: held at zero outside LOAD so each frame starts from zero
  always_ff @(posedge clk_50m) begin
    if (rst || (state != ST_LOAD)) begin
      rd_cnt <= '0;
    end else if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  // FIFO Q is valid the cycle after the read strobe, so fft_start follows it
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      fft_start <= 1'b0;
    end else begin
      fft_start <= fifo_rd_en;
    end
  end

  // Frame completion pulse and wrapping completed-frame count
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= eop_hit;
      if (eop_hit) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Sticky error flags, cleared only by rst
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if (underflow_hit) begin
        err_underflow <= 1'b1;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: gating table in ARM, nominal
// frame, back-to-back start, underflow stall, drain timeout and rst mid-LOAD.
module tb_fft_frame_sched;

  localparam int FRAME_LEN = 1024;
  localparam int CNT_W     = 11;
  localparam int RST_CYC   = 4;
  localparam int DRAIN_TO  = 4096;

  typedef struct {
    logic             en;
    logic             dr;
    logic [CNT_W-1:0] wnum;
    logic             exp_load;
  } vec_t;

  logic             clk_50m = 1'b0;
  logic             rst;
  logic             enable;
  logic             disp_ready;
  logic [CNT_W-1:0] fifo_wnum;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             fft_rst;
  logic             fft_start;
  logic             fft_valid;
  logic             fft_eop;
  logic             busy;
  logic             frame_done;
  logic [15:0]      frame_cnt;
  logic             err_underflow;
  logic             err_timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdq[$];
  int fdq[$];
  int rd_total = 0;
  int st_total = 0;
  int done_total = 0;
  int first_rd = -1;
  int last_rd = -1;

  fft_frame_sched #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W),
    .RST_CYC   (RST_CYC),
    .DRAIN_TO  (DRAIN_TO)
  ) dut (
    .clk_50m       (clk_50m),
    .rst           (rst),
    .enable        (enable),
    .disp_ready    (disp_ready),
    .fifo_wnum     (fifo_wnum),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fft_rst       (fft_rst),
    .fft_start     (fft_start),
    .fft_valid     (fft_valid),
    .fft_eop       (fft_eop),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each read pushes its cycle, each fft_start must pop a read
  // from exactly one cycle earlier; each driven eop pushes the frame count
  // that the matching frame_done must show.
  always @(negedge clk_50m) begin
    int rc;
    if (fifo_rd_en) begin
      rdq.push_back(cyc);
      rd_total++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      chk("rd_while_empty", fifo_empty, 0);
    end
    if (fft_start) begin
      st_total++;
      chk("start_has_read", rdq.size() > 0, 1);
      if (rdq.size() > 0) begin
        rc = rdq.pop_front();
        chk("start_lag", cyc - rc, 1);
      end
    end
    if (frame_done) begin
      done_total++;
      chk("done_expected", fdq.size() > 0, 1);
      if (fdq.size() > 0) chk("frame_cnt_at_done", frame_cnt, fdq.pop_front());
    end
  end

  task automatic wait_reads(input int n, input int budget, input string name);
    int k = 0;
    while (rd_total < n && k < budget) begin
      @(negedge clk_50m); #1;
      k++;
    end
    chk(name, rd_total >= n, 1);
  endtask

  // Counts fft_rst-high cycles starting with the current one
  task automatic count_rst(input string name);
    int n = 0;
    while (fft_rst === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_50m); #1;
    end
    chk(name, n, RST_CYC);
  endtask

  initial begin
    vec_t tbl[6];
    int base;
    int sbase;
    int c0;
    int eop_cyc;
    int lr;
    int k;
    logic prev_to;

    tbl[0] = '{en: 1'b1, dr: 1'b0, wnum: 11'd1023, exp_load: 1'b0};
    tbl[1] = '{en: 1'b1, dr: 1'b0, wnum: 11'd1024, exp_load: 1'b0};
    tbl[2] = '{en: 1'b0, dr: 1'b1, wnum: 11'd1024, exp_load: 1'b0};
    tbl[3] = '{en: 1'b1, dr: 1'b1, wnum: 11'd1023, exp_load: 1'b0};
    tbl[4] = '{en: 1'b1, dr: 1'b1, wnum: 11'd1024, exp_load: 1'b1};
    tbl[5] = '{en: 1'b1, dr: 1'b1, wnum: 11'd2047, exp_load: 1'b1};

    rst = 1'b1; enable = 1'b0; disp_ready = 1'b0; fifo_wnum = '0;
    fifo_empty = 1'b1; fft_valid = 1'b0; fft_eop = 1'b0;

    // Reset held for three clock edges
    @(posedge clk_50m);
    @(posedge clk_50m);
    @(negedge clk_50m); #1;
    chk("rst_fft_rst", fft_rst, 1);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_fft_start", fft_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_underflow", err_underflow, 0);
    chk("rst_err_timeout", err_timeout, 0);
    @(posedge clk_50m); #1;
    rst = 1'b0;
    @(negedge clk_50m); #1;
    count_rst("rst_release_len");
    chk("arm_busy", busy, 0);

    // No reads while the FIFO reports no samples
    @(posedge clk_50m); #1;
    enable = 1'b1; disp_ready = 1'b1; fifo_empty = 1'b0; fifo_wnum = '0;
    repeat (10) @(posedge clk_50m);
    #1;
    chk("no_read_wnum0", rd_total, 0);

    // ARM gating table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_50m); #1;
      enable = tbl[i].en; disp_ready = tbl[i].dr; fifo_wnum = tbl[i].wnum; fifo_empty = 1'b0;
      @(negedge clk_50m); #1;
      chk($sformatf("tbl%0d_rd_same", i), fifo_rd_en, 0);
      @(negedge clk_50m); #1;
      chk($sformatf("tbl%0d_rd_next", i), fifo_rd_en, tbl[i].exp_load);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_load);
      if (tbl[i].exp_load) begin
        enable = 1'b0; disp_ready = 1'b0; fifo_wnum = '0;
        @(posedge clk_50m); #1;
        rst = 1'b1;
        @(posedge clk_50m); #1;
        rst = 1'b0;
        @(negedge clk_50m); #1;
        count_rst($sformatf("tbl%0d_rerst_len", i));
      end
    end

    // Stray eop in ARM
    @(posedge clk_50m); #1;
    fft_valid = 1'b1; fft_eop = 1'b1;
    @(posedge clk_50m); #1;
    fft_valid = 1'b0; fft_eop = 1'b0;
    repeat (3) @(negedge clk_50m);
    #1;
    chk("stray_eop_done", done_total, 0);
    chk("stray_eop_cnt", frame_cnt, 0);

    // Nominal frame
    base = rd_total; sbase = st_total; first_rd = -1;
    @(posedge clk_50m); #1;
    enable = 1'b1; disp_ready = 1'b1; fifo_wnum = 11'd1024; fifo_empty = 1'b0;
    c0 = cyc;
    wait_reads(base + FRAME_LEN, 1200, "nom_reads_done");
    chk("nom_first_rd", first_rd - c0, 1);
    chk("nom_contiguous", last_rd - first_rd, FRAME_LEN - 1);
    repeat (5) @(negedge clk_50m);
    #1;
    chk("nom_no_extra_reads", rd_total - base, FRAME_LEN);
    chk("nom_starts", st_total - sbase, FRAME_LEN);
    chk("nom_busy_drain", busy, 1);
    chk("nom_err_underflow", err_underflow, 0);

    // eop with enable still high: next frame follows back-to-back
    @(posedge clk_50m); #1;
    fft_valid = 1'b1; fft_eop = 1'b1;
    fdq.push_back(1);
    eop_cyc = cyc;
    base = rd_total; first_rd = -1;
    @(posedge clk_50m); #1;
    fft_valid = 1'b0; fft_eop = 1'b0;
    @(negedge clk_50m); #1;
    chk("nom_done_pulse", done_total, 1);
    chk("nom_frame_cnt", frame_cnt, 1);
    @(negedge clk_50m); #1;
    chk("nom_done_one_cycle", done_total, 1);
    chk("b2b_gap", first_rd - eop_cyc, 2);

    // Underflow stall after the 100th read of the second frame
    wait_reads(base + 100, 200, "uf_reach_100");
    @(posedge clk_50m); #1;
    fifo_empty = 1'b1;
    repeat (5) @(posedge clk_50m);
    #1;
    fifo_empty = 1'b0;
    wait_reads(base + FRAME_LEN, 1200, "uf_reads_done");
    enable = 1'b0;
    lr = last_rd;
    chk("uf_span", last_rd - first_rd, FRAME_LEN - 1 + 5);
    chk("uf_flag", err_underflow, 1);

    // No eop: drain timeout and FFT re-reset
    k = 0; prev_to = 1'b0;
    while (fft_rst !== 1'b1 && k < 5000) begin
      prev_to = err_timeout;
      @(negedge clk_50m); #1;
      k++;
    end
    chk("uf_total_reads", rd_total - base, FRAME_LEN);
    chk("to_rise_cycle", cyc - lr, DRAIN_TO + 1);
    chk("to_flag", err_timeout, 1);
    chk("to_flag_prev", prev_to, 0);
    count_rst("to_rerst_len");
    chk("to_frame_cnt", frame_cnt, 1);
    chk("to_done_total", done_total, 1);
    chk("uf_flag_sticky", err_underflow, 1);

    // rst in the middle of LOAD
    base = rd_total; first_rd = -1;
    @(posedge clk_50m); #1;
    enable = 1'b1;
    wait_reads(base + 500, 600, "mid_reach_500");
    @(posedge clk_50m); #1;
    rst = 1'b1; enable = 1'b0;
    @(negedge clk_50m); #1;
    chk("mid_rd_in_rst", fifo_rd_en, 0);
    @(posedge clk_50m); #1;
    rst = 1'b0;
    @(negedge clk_50m); #1;
    chk("mid_rd_after", fifo_rd_en, 0);
    chk("mid_fft_start", fft_start, 0);
    chk("mid_frame_cnt", frame_cnt, 0);
    chk("mid_err_underflow", err_underflow, 0);
    chk("mid_err_timeout", err_timeout, 0);
    count_rst("mid_rerst_len");
    chk("mid_reads", rd_total - base, 500);
    chk("sb_reads_drained", rdq.size(), 0);
    chk("sb_done_drained", fdq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
